// File: rtl/bp_me_cache_mem_arbiter_if.sv
// Bundle of the command/response handshake signals between the requesting
// caches, the arbiter and the shared memory channel pair.
// slave  : arbiter view.
// master : environment view (caches plus memory), the mirror of slave.
interface bp_me_cache_mem_arbiter_if
  #(parameter int num_req_p         = 2
   ,parameter int cmd_width_p       = 128
   ,parameter int resp_width_p      = 128
   ,parameter int outstanding_els_p = 4
   );

    localparam int cnt_width_lp = $clog2(outstanding_els_p+1);

    // requester command side
    logic [num_req_p-1:0][cmd_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]                  req_cmd_v_i;
    logic [num_req_p-1:0]                  req_cmd_ready_and_o;

    // memory command side
    logic [cmd_width_p-1:0]                mem_cmd_o;
    logic                                  mem_cmd_v_o;
    logic                                  mem_cmd_ready_and_i;

    // memory response side
    logic [resp_width_p-1:0]               mem_resp_i;
    logic                                  mem_resp_v_i;
    logic                                  mem_resp_yumi_o;

    // requester response side
    logic [resp_width_p-1:0]               req_resp_o;
    logic [num_req_p-1:0]                  req_resp_v_o;
    logic [num_req_p-1:0]                  req_resp_yumi_i;

    logic [cnt_width_lp-1:0]               outstanding_o;

    modport slave
        (input  req_cmd_i, req_cmd_v_i, mem_cmd_ready_and_i
        ,input  mem_resp_i, mem_resp_v_i, req_resp_yumi_i
        ,output req_cmd_ready_and_o, mem_cmd_o, mem_cmd_v_o
        ,output mem_resp_yumi_o, req_resp_o, req_resp_v_o, outstanding_o
        );

    modport master
        (output req_cmd_i, req_cmd_v_i, mem_cmd_ready_and_i
        ,output mem_resp_i, mem_resp_v_i, req_resp_yumi_i
        ,input  req_cmd_ready_and_o, mem_cmd_o, mem_cmd_v_o
        ,input  mem_resp_yumi_o, req_resp_o, req_resp_v_o, outstanding_o
        );

endinterface

// File: rtl/bp_me_cache_mem_arbiter.sv
// Shares one memory command/response channel pair between num_req_p caches.
// Commands are granted round-robin and forwarded combinationally. The winner
// ID of every issued command goes into an in-order tag FIFO, and the FIFO head
// steers each memory response back to the cache that issued it.
module bp_me_cache_mem_arbiter
  #(parameter int num_req_p         = 2
   ,parameter int cmd_width_p       = 128
   ,parameter int resp_width_p      = 128
   ,parameter int outstanding_els_p = 4
   ,localparam int lg_req_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1
   )
   (input  logic                          clk_i
   ,input  logic                          reset_i
   ,bp_me_cache_mem_arbiter_if.slave      bus
   );

    localparam int lg_els_lp    = (outstanding_els_p > 1) ? $clog2(outstanding_els_p) : 1;
    localparam int cnt_width_lp = $clog2(outstanding_els_p+1);

    typedef logic [lg_req_lp-1:0] req_id_t;

    // registered state
    req_id_t                 rr_q, rr_d;
    logic                    lock_q, lock_d;
    req_id_t                 lock_id_q, lock_id_d;
    req_id_t                 tags_q [outstanding_els_p];
    req_id_t                 tags_d [outstanding_els_p];
    logic [lg_els_lp-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;

    // combinational
    req_id_t grant, head, hi_id, lo_id;
    logic    hi_found;
    logic    any_v, full, empty;
    logic    cmd_v, push, resp_v, pop;

    assign any_v = |bus.req_cmd_v_i;
    assign full  = (count_q == cnt_width_lp'(outstanding_els_p));
    assign empty = (count_q == '0);
    assign head  = tags_q[rptr_q];

    // Round-robin search: lowest valid index at/after rr_q, else lowest valid
    // overall (the wrap). A stalled command keeps its grant while locked.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int j = num_req_p-1; j >= 0; j--) begin
            if (bus.req_cmd_v_i[j]) begin
                lo_id = req_id_t'(j);
                if (j >= int'(rr_q)) begin
                    hi_id    = req_id_t'(j);
                    hi_found = 1'b1;
                end
            end
        end
        if (lock_q)
            grant = lock_id_q;
        else if (hi_found)
            grant = hi_id;
        else
            grant = lo_id;
    end

    // Command path: issue only on registered not-full; outputs held at zero
    // while reset is asserted so they drop immediately on an async reset.
    assign cmd_v = reset_i & any_v & ~full;
    assign push  = cmd_v & bus.mem_cmd_ready_and_i;

    assign bus.mem_cmd_o   = bus.req_cmd_i[grant];
    assign bus.mem_cmd_v_o = cmd_v;

    // Ready goes only to the granted requester.
    always_comb begin
        bus.req_cmd_ready_and_o = '0;
        if (push)
            bus.req_cmd_ready_and_o[grant] = 1'b1;
    end

    // Response path: only the FIFO head owner sees valid; its yumi pops.
    assign resp_v = reset_i & bus.mem_resp_v_i & ~empty;
    assign pop    = resp_v & bus.req_resp_yumi_i[head];

    assign bus.req_resp_o      = bus.mem_resp_i;
    assign bus.mem_resp_yumi_o = pop;
    assign bus.outstanding_o   = count_q;

    // One-hot response valid steered by the head tag.
    always_comb begin
        bus.req_resp_v_o = '0;
        if (resp_v)
            bus.req_resp_v_o[head] = 1'b1;
    end

    // Next-state for rr pointer, grant lock and the tag FIFO.
    always_comb begin
        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        tags_d    = tags_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;

        if (push) begin
            lock_d         = 1'b0;
            rr_d           = (grant == req_id_t'(num_req_p-1)) ? '0 : grant + req_id_t'(1);
            tags_d[wptr_q] = grant;
            wptr_d         = (wptr_q == lg_els_lp'(outstanding_els_p-1)) ? '0
                                                                         : wptr_q + lg_els_lp'(1);
        end else if (cmd_v) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (pop)
            rptr_d = (rptr_q == lg_els_lp'(outstanding_els_p-1)) ? '0
                                                                 : rptr_q + lg_els_lp'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; async reset drops every in-flight tag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            tags_q    <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            tags_q    <= tags_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // A response with nothing outstanding means the memory lost sync.
    resp_without_cmd_a: assert property (@(posedge clk_i) disable iff (!reset_i)
                                         !(bus.mem_resp_v_i && empty));

endmodule

// File: tb/tb_bp_me_cache_mem_arbiter.sv
// Randomized bench for bp_me_cache_mem_arbiter. A queue-based reference model
// (rr pointer, grant lock, list of issued requester IDs) predicts every output
// each cycle; directed phases bias the random knobs toward the interesting cases.
module tb_bp_me_cache_mem_arbiter;

    localparam int R  = 2;
    localparam int CW = 128;
    localparam int RW = 128;
    localparam int N  = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    always #5 clk_i = ~clk_i;

    bp_me_cache_mem_arbiter_if #(.num_req_p(R), .cmd_width_p(CW), .resp_width_p(RW),
                                 .outstanding_els_p(N)) bus ();

    bp_me_cache_mem_arbiter #(.num_req_p(R), .cmd_width_p(CW), .resp_width_p(RW),
                              .outstanding_els_p(N)) dut
        (.clk_i   (clk_i)
        ,.reset_i (reset_i)
        ,.bus     (bus)
        );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    endtask

    // reference model state
    int       rr_m;
    bit       lock_m;
    int       lock_id_m;
    int       tagq[$];

    // requester / memory stimulus state
    bit              hold_v   [R];
    logic [CW-1:0]   hold_cmd [R];
    bit              mem_rdy_t, resp_v_t;
    logic [RW-1:0]   resp_d_t;
    logic [R-1:0]    yumi_t;

    // knobs (percent)
    int pv [R];
    int pready, presp, pyumi;
    bit yumi_other_only;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive();
        for (int r = 0; r < R; r++) begin
            if (!hold_v[r]) begin
                hold_v[r] = ($urandom_range(99) < pv[r]);
                if (hold_v[r]) hold_cmd[r] = rnd128();
            end
            bus.req_cmd_v_i[r] = hold_v[r];
            bus.req_cmd_i[r]   = hold_cmd[r];
        end
        mem_rdy_t = ($urandom_range(99) < pready);
        resp_v_t  = (tagq.size() > 0) && ($urandom_range(99) < presp);
        resp_d_t  = rnd128();
        for (int r = 0; r < R; r++) yumi_t[r] = ($urandom_range(99) < pyumi);
        if (yumi_other_only && tagq.size() > 0) begin
            yumi_t = '1;
            yumi_t[tagq[0]] = 1'b0;
        end
        bus.mem_cmd_ready_and_i = mem_rdy_t;
        bus.mem_resp_v_i        = resp_v_t;
        bus.mem_resp_i          = resp_d_t;
        bus.req_resp_yumi_i     = yumi_t;
    endtask

    // Predict outputs for the driven inputs, compare, then commit the edge.
    task automatic check_cycle();
        int g;
        bit anyv, full, cv, hs, y;
        logic [R-1:0] exp_rdy, exp_rv;
        full = (tagq.size() == N);
        anyv = 1'b0;
        for (int r = 0; r < R; r++) anyv |= hold_v[r];
        g = rr_m;
        if (lock_m) g = lock_id_m;
        else begin
            for (int k = R-1; k >= 0; k--)
                if (hold_v[(rr_m + k) % R]) g = (rr_m + k) % R;
        end
        cv = anyv && !full;
        hs = cv && mem_rdy_t;
        exp_rdy = '0;
        if (hs) exp_rdy[g] = 1'b1;
        exp_rv = '0;
        if (resp_v_t && tagq.size() > 0) exp_rv[tagq[0]] = 1'b1;
        y = (exp_rv != '0) && yumi_t[tagq[0]];

        chk("mem_cmd_v", 128'(bus.mem_cmd_v_o), 128'(cv));
        chk("cmd_ready", 128'(bus.req_cmd_ready_and_o), 128'(exp_rdy));
        if (cv) chk("mem_cmd", bus.mem_cmd_o, hold_cmd[g]);
        chk("resp_v", 128'(bus.req_resp_v_o), 128'(exp_rv));
        chk("resp_yumi", 128'(bus.mem_resp_yumi_o), 128'(y));
        if (exp_rv != '0) chk("resp_data", bus.req_resp_o, resp_d_t);
        chk("outstanding", 128'(bus.outstanding_o), 128'(tagq.size()));

        if (y) void'(tagq.pop_front());
        if (hs) begin
            tagq.push_back(g);
            rr_m      = (g + 1) % R;
            lock_m    = 1'b0;
            hold_v[g] = 1'b0;
        end else if (cv) begin
            lock_m    = 1'b1;
            lock_id_m = g;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            #1;
            check_cycle();
            @(negedge clk_i);
        end
    endtask

    task automatic knobs(input int v0, input int v1, input int rdy, input int rsp, input int ym);
        pv[0] = v0; pv[1] = v1; pready = rdy; presp = rsp; pyumi = ym;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_v"}, 128'(bus.mem_cmd_v_o), 128'(0));
        chk({tag, "_cmd_rdy"}, 128'(bus.req_cmd_ready_and_o), 128'(0));
        chk({tag, "_resp_v"}, 128'(bus.req_resp_v_o), 128'(0));
        chk({tag, "_resp_yumi"}, 128'(bus.mem_resp_yumi_o), 128'(0));
        chk({tag, "_outst"}, 128'(bus.outstanding_o), 128'(0));
    endtask

    initial begin
        rr_m = 0; lock_m = 0; lock_id_m = 0;
        yumi_other_only = 0;
        for (int r = 0; r < R; r++) begin hold_v[r] = 0; hold_cmd[r] = '0; end
        knobs(0, 0, 0, 0, 0);
        bus.req_cmd_i = '0; bus.req_cmd_v_i = '0; bus.mem_cmd_ready_and_i = 1'b0;
        bus.mem_resp_i = '0; bus.mem_resp_v_i = 1'b0; bus.req_resp_yumi_i = '0;
        mem_rdy_t = 0; resp_v_t = 0; resp_d_t = '0; yumi_t = '0;

        #2 chk_reset_outs("por");
        @(negedge clk_i);
        reset_i = 1'b1;

        // single requester, 3 back-to-back commands, then drain
        knobs(100, 0, 100, 0, 0);   run(3);
        knobs(0, 0, 100, 100, 100); run(5);

        // both requesters saturating: alternating grants and responses
        knobs(100, 100, 100, 100, 100); run(12);
        knobs(0, 0, 100, 100, 100);     run(8);

        // stall with grant lock while req 1 shows up
        knobs(100, 0, 0, 0, 0);         run(1);
        knobs(100, 100, 0, 0, 0);       run(4);
        knobs(100, 100, 100, 0, 0);     run(3);

        // fill to full, then pop with a command pending the same cycle
        knobs(100, 100, 100, 0, 0);     run(4);
        knobs(100, 100, 100, 100, 100); run(3);

        // only non-head requesters assert yumi
        knobs(0, 0, 0, 100, 0);
        yumi_other_only = 1;            run(3);
        yumi_other_only = 0;
        knobs(0, 0, 0, 100, 100);       run(8);

        // two outstanding, then async reset between clock edges
        knobs(100, 0, 100, 0, 0);       run(2);
        knobs(100, 100, 100, 0, 0);
        drive();
        #3 reset_i = 1'b0;
        bus.mem_resp_v_i = 1'b0;
        #1 chk_reset_outs("arst");
        tagq.delete(); rr_m = 0; lock_m = 0;
        @(posedge clk_i); #1 chk_reset_outs("arst_hold");
        @(negedge clk_i);
        reset_i = 1'b1;
        run(4);

        // free-running random traffic with knobs reshuffled periodically
        for (int blk = 0; blk < 40; blk++) begin
            knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                  $urandom_range(100), $urandom_range(100));
            run(50);
        end
        knobs(0, 0, 100, 100, 100);     run(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
